fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//  Drains a fifo through its pop interface and presents each word on a registered valid/ready stream.
//  Frames the stream into bursts of burstLength beats and flags the final beat with outLast.
//  Sits between a fifo's read side and any stream consumer (bus master, serializer, accelerator input).
//  Sustains one word per cycle while the fifo is non-empty and the consumer is ready.
// PARAMETERS
//  bitWidth     32  width of fifo words and of outData
//  maxBurstLog   8  width of burstLength and beatCount; largest burst is 2**maxBurstLog-1
// PORTS
//  clock        in   1              single clock; all state updates on its rising edge
//  reset        in   1              synchronous, active-high
//  enable       in   1              1: fetch from fifo; 0: stop popping, drain buffered words
//  burstLength  in   maxBurstLog    beats per burst; sampled when beatCount==0; 0 is treated as 1
//  fifoEmpty    in   1              fifo empty flag
//  fifoPopData  in   bitWidth       fifo read data; valid the cycle after a pop, held until next pop
//  fifoPop      out  1              one-cycle pop strobe to fifo
//  outValid     out  1              outData/outLast valid
//  outReady     in   1              consumer accepts beat when outValid&&outReady
//  outData      out  bitWidth       registered beat data
//  outLast      out  1              final beat of current burst
//  beatCount    out  maxBurstLog    beats accepted so far in current burst
//  busy         out  1              word in flight or buffered
// BEHAVIOUR
//  Reset: fifoPop=0, outValid=0, outLast=0, outData=0, beatCount=0, busy=0, buffer empty, no pop in flight.
//  Buffer: 2-entry output buffer, head drives outData/outLast; occ in {0,1,2}.
//  inFlight: register = fifoPop of previous cycle.
//  Pop rule (combinational): fifoPop = enable && !fifoEmpty && !reset && (occ + inFlight - pushOut) < 2,
//   pushOut = outValid&&outReady this cycle; never pop when fifoEmpty=1.
//  Capture: cycle after fifoPop=1, fifoPopData written to buffer tail; latency pop->outValid = 2 cycles.
//  outValid = (occ!=0); head dequeued on outValid&&outReady; enqueue+dequeue same cycle keeps occ.
//  outData and outLast stable while outValid&&!outReady (AXI-style hold); outValid never drops without accept.
//  Burst framing: curLen latched from burstLength (0->1) when a word is captured with beatCount==0;
//   outLast tagged at capture for the word whose burst index == curLen-1.
//   beatCount increments on accept, wraps to 0 after the outLast beat.
//  burstLength changes mid-burst are ignored until the next burst starts.
//  enable=0: no new pops; in-flight pop still captured; buffered words still delivered; framing state held.
//  busy = inFlight || occ!=0.
//  Reset mid-operation: in-flight and buffered words discarded, counters cleared next cycle; fifo itself not touched.
//  Width rules: beat counters wrap modulo 2**maxBurstLog; curLen compare is unsigned.
// STRUCTURE
//  Shared package: burst-counter width helper ($clog2 wrapper), stream beat struct {data,last}.
//  Sub-module stream_skid_buffer (2-entry, bitWidth+1 wide, valid/ready both sides) holds words;
//   top level contains pop control, inFlight register and burst framing.
// TESTING (bench pairs this block with the team's fifo, nrOfEntries=16, bitWidth=32)
//  Push 0x1..0x8, enable=1, outReady=1, burstLength=4 -> beats 1..8 on consecutive cycles, outLast on 4 and 8.
//  Push 8 words, outReady toggles 1,0 each cycle -> no loss/duplication, outData held while stalled, fifoPop never with fifoEmpty=1.
//  Push 3 words, burstLength=0 -> every beat has outLast=1, beatCount stays 0.
//  Push 10 words, outReady=0 -> exactly 2 pops then fifoPop=0; outReady=1 -> remaining 8 drain in order.
//  Deassert enable after 2 accepts with 6 queued -> at most 2 buffered words delivered, busy falls, fifo keeps 4.
//  Assert reset mid-burst with occ=2 -> next cycle outValid=0, beatCount=0, busy=0; later words restart at outLast framing beat 1.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the fifo stream reader: beat payload layout
// and counter sizing.
package fifo_stream_reader_pkg;

  localparam int unsigned BEAT_DATA_W = 32;
  localparam int unsigned BUF_DEPTH   = 2;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   last;
  } stream_beat_t;

  // Bits needed to hold a count from 0 up to and including max_val.
  function automatic int unsigned burst_cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Fifo pop side plus outgoing valid/ready beat stream of the fifo stream reader.
interface fifo_stream_reader_if
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned bitWidth = BEAT_DATA_W
) ();

  logic                fifoEmpty;
  logic [bitWidth-1:0] fifoPopData;
  logic                fifoPop;
  logic                outValid;
  logic                outReady;
  logic [bitWidth-1:0] outData;
  logic                outLast;

  modport master (
    input  fifoEmpty, fifoPopData, outReady,
    output fifoPop, outValid, outData, outLast
  );

  modport slave (
    output fifoEmpty, fifoPopData, outReady,
    input  fifoPop, outValid, outData, outLast
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buffer.sv
// Two-entry output buffer with valid/ready on both sides; head entry drives
// the read side and is held stable until it is accepted.
module fifo_stream_reader_skid_buffer
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned width = BEAT_DATA_W + 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    wr_valid,
  output logic                                    wr_ready,
  input  logic [width-1:0]                        wr_data,
  output logic                                    rd_valid,
  input  logic                                    rd_ready,
  output logic [width-1:0]                        rd_data,
  output logic [burst_cnt_width(BUF_DEPTH)-1:0]   occ
);

  localparam int unsigned OCC_W = burst_cnt_width(BUF_DEPTH);

  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic [OCC_W-1:0] count;
  logic             push;
  logic             pop;

  // A full buffer still takes a word when the head leaves in the same cycle.
  assign wr_ready = (count != OCC_W'(BUF_DEPTH)) || rd_ready;
  assign push     = wr_valid && wr_ready;
  assign pop      = (count != '0) && rd_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == '0) head <= wr_data;
          else             tail <= wr_data;
          count <= count + OCC_W'(1);
        end
        2'b01: begin
          head  <= tail;
          count <= count - OCC_W'(1);
        end
        2'b11: begin
          if (count == OCC_W'(1)) begin
            head <= wr_data;
          end else begin
            head <= tail;
            tail <= wr_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = head;
  assign occ      = count;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fifo into a registered valid/ready stream framed into bursts of
// burstLength beats, with outLast marking the final beat of each burst.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned bitWidth    = BEAT_DATA_W,
  parameter int unsigned maxBurstLog = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [maxBurstLog-1:0] burstLength,
  fifo_stream_reader_if.master   bus,
  output logic [maxBurstLog-1:0] beatCount,
  output logic                   busy
);

  localparam int unsigned CNT_W = burst_cnt_width((32'd1 << maxBurstLog) - 32'd1);
  localparam int unsigned OCC_W = burst_cnt_width(BUF_DEPTH);

  logic               in_flight;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W:0]     room_use;
  logic               push_out;
  logic               pop_c;
  logic               wr_ready;
  logic               cap_fire;
  logic               cap_last;
  logic [CNT_W-1:0]   cap_idx;
  logic [CNT_W-1:0]   cur_len;
  logic [CNT_W-1:0]   len_sel;
  logic [CNT_W-1:0]   beat_cnt;
  logic [bitWidth:0]  head_word;

  // Slots committed next cycle: buffered + in flight, minus the beat leaving now.
  assign push_out = bus.outValid && bus.outReady;
  assign room_use = (OCC_W+1)'(occ) + (OCC_W+1)'(in_flight) - (OCC_W+1)'(push_out);
  assign pop_c    = enable && !bus.fifoEmpty && !reset
                    && (room_use < (OCC_W+1)'(BUF_DEPTH));
  assign bus.fifoPop = pop_c;
  assign cap_fire    = in_flight && wr_ready;

  // Burst length is taken from the input only for the first word of a burst.
  always_comb begin
    len_sel = cur_len;
    if (cap_idx == '0) begin
      len_sel = (burstLength == '0) ? CNT_W'(1) : CNT_W'(burstLength);
    end
    cap_last = (cap_idx == (len_sel - CNT_W'(1)));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight <= 1'b0;
      cap_idx   <= '0;
      cur_len   <= CNT_W'(1);
      beat_cnt  <= '0;
    end else begin
      in_flight <= pop_c;
      if (cap_fire) begin
        if (cap_idx == '0) cur_len <= len_sel;
        cap_idx <= cap_last ? '0 : cap_idx + CNT_W'(1);
      end
      if (push_out) begin
        beat_cnt <= head_word[0] ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end

  fifo_stream_reader_skid_buffer #(
    .width(bitWidth + 1)
  ) u_stream_skid_buffer (
    .clock   (clock),
    .reset   (reset),
    .wr_valid(in_flight),
    .wr_ready(wr_ready),
    .wr_data ({bus.fifoPopData, cap_last}),
    .rd_valid(bus.outValid),
    .rd_ready(bus.outReady),
    .rd_data (head_word),
    .occ     (occ)
  );

  assign bus.outData = head_word[bitWidth:1];
  assign bus.outLast = head_word[0];
  assign beatCount   = maxBurstLog'(beat_cnt);
  assign busy        = in_flight || (occ != '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural fifo, capture-time burst model
// feeding a scoreboard, and a monitor checking every accepted beat.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int unsigned BW         = 32;
  localparam int unsigned BL         = 8;
  localparam int unsigned FIFO_DEPTH = 16;

  logic          clk           = 1'b0;
  logic          reset         = 1'b1;
  logic          enable        = 1'b0;
  logic [BL-1:0] burst_length  = BL'(4);
  logic          out_ready     = 1'b0;
  logic          fifo_empty    = 1'b1;
  logic [BW-1:0] fifo_pop_data = '0;
  logic [BL-1:0] beat_count;
  logic          busy;

  fifo_stream_reader_if #(.bitWidth(BW)) bus ();

  assign bus.fifoEmpty   = fifo_empty;
  assign bus.fifoPopData = fifo_pop_data;
  assign bus.outReady    = out_ready;

  fifo_stream_reader #(.bitWidth(BW), .maxBurstLog(BL)) dut (
    .clock      (clk),
    .reset      (reset),
    .enable     (enable),
    .burstLength(burst_length),
    .bus        (bus),
    .beatCount  (beat_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired before the required condition", name);
  endtask

  logic [BW-1:0] fifo_q[$];
  logic [BW-1:0] push_req[$];
  stream_beat_t  exp_q[$];
  int            acc_cyc[$];

  logic          pop_s  = 1'b0;
  logic          rst_s  = 1'b1;
  logic [BL-1:0] bl_s   = '0;
  int            pops    = 0;
  int            accepts = 0;
  int            cyc     = 0;

  // Behavioural fifo plus burst model evaluated at the cycle a word is captured.
  initial begin
    bit            cap_pend = 0;
    logic [BW-1:0] cap_data = '0;
    int unsigned   m_idx = 0;
    int unsigned   m_len = 1;
    stream_beat_t  b;
    logic [BW-1:0] w;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_s) begin
        exp_q.delete();
        m_idx    = 0;
        cap_pend = 0;
      end else if (cap_pend) begin
        if (m_idx == 0) m_len = (bl_s == '0) ? 1 : int'(bl_s);
        b.data = cap_data;
        b.last = (m_idx == m_len - 1);
        exp_q.push_back(b);
        m_idx    = b.last ? 0 : m_idx + 1;
        cap_pend = 0;
      end
      if (pop_s && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_pop_data <= w;
        cap_data = w;
        cap_pend = 1;
        pops++;
      end
      while (push_req.size() > 0) fifo_q.push_back(push_req.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Monitor: scoreboard compare on every accepted beat, plus stall-hold checks.
  initial begin
    int            exp_bc = 0;
    bit            hold_pend = 0;
    logic [BW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;
    stream_beat_t  e;
    forever begin
      @(negedge clk);
      pop_s = bus.fifoPop;
      rst_s = reset;
      bl_s  = burst_length;
      if (bus.fifoPop) check("pop_while_empty", fifo_empty, 0);
      if (reset) begin
        exp_bc    = 0;
        hold_pend = 0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", bus.outValid, 1);
          check("hold_data", bus.outData, hold_data);
          check("hold_last", bus.outLast, hold_last);
        end
        if (bus.outValid && bus.outReady) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            e = exp_q.pop_front();
            check("beat_data", bus.outData, e.data);
            check("beat_last", bus.outLast, e.last);
            check("beat_count", beat_count, exp_bc);
            exp_bc = e.last ? 0 : (exp_bc + 1) % 256;
          end
          accepts++;
          acc_cyc.push_back(cyc);
        end
        hold_pend = bus.outValid && !bus.outReady;
        hold_data = bus.outData;
        hold_last = bus.outLast;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [BW-1:0] d);
    push_req.push_back(d);
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int n = 0;
    while (accepts < target && n < budget) begin
      step();
      n++;
    end
    if (accepts < target) fail_now(name);
  endtask

  function automatic bit idle_ok(input bit need_empty);
    return !busy && exp_q.size() == 0 &&
           (!need_empty || (fifo_q.size() == 0 && push_req.size() == 0));
  endfunction

  task automatic wait_idle(input bit need_empty, input int budget, input string name);
    int n = 0;
    while (!idle_ok(need_empty) && n < budget) begin
      step();
      n++;
    end
    if (!idle_ok(need_empty)) fail_now(name);
  endtask

  initial begin
    int base;
    int p0;
    int a0;
    int n;

    step();
    step();
    @(negedge clk);
    check("rst_fifo_pop", bus.fifoPop, 0);
    check("rst_out_valid", bus.outValid, 0);
    check("rst_out_last", bus.outLast, 0);
    check("rst_out_data", bus.outData, 0);
    check("rst_beat_count", beat_count, 0);
    check("rst_busy", busy, 0);

    step();
    reset = 0; enable = 1; out_ready = 1; burst_length = BL'(4);

    // Back-to-back throughput with bursts of 4.
    base = accepts;
    for (int i = 1; i <= 8; i++) push_word(BW'(i));
    wait_accepts(base + 8, 60, "t1_wait");
    if (acc_cyc.size() >= base + 8)
      check("t1_back_to_back", acc_cyc[base + 7] - acc_cyc[base], 7);
    wait_idle(1, 50, "t1_idle");

    // Consumer alternates ready every cycle.
    base = accepts;
    for (int i = 0; i < 8; i++) push_word(BW'($urandom));
    n = 0;
    while (accepts < base + 8 && n < 100) begin
      out_ready = ~out_ready;
      step();
      n++;
    end
    if (accepts < base + 8) fail_now("t2_wait");
    out_ready = 1;
    wait_idle(1, 50, "t2_idle");

    // Zero burst length behaves as single-beat bursts.
    burst_length = '0;
    base = accepts;
    for (int i = 0; i < 3; i++) push_word(BW'(32'hA0 + i));
    wait_accepts(base + 3, 40, "t3_wait");
    wait_idle(1, 40, "t3_idle");
    check("t3_beat_count", beat_count, 0);

    // Stalled consumer: only two words may be fetched.
    burst_length = BL'(4);
    out_ready = 0;
    p0 = pops;
    base = accepts;
    for (int i = 0; i < 10; i++) push_word(BW'(32'h100 + i));
    repeat (12) step();
    check("t4_pops_while_stalled", pops - p0, 2);
    check("t4_valid_while_stalled", bus.outValid, 1);
    out_ready = 1;
    wait_accepts(base + 10, 60, "t4_wait");
    wait_idle(1, 40, "t4_idle");

    // Enable dropped after two accepts with six words still queued.
    base = accepts;
    for (int i = 0; i < 8; i++) push_word(BW'(32'h200 + i));
    wait_accepts(base + 2, 40, "t5_wait");
    enable = 0;
    a0 = accepts;
    wait_idle(0, 40, "t5_idle");
    check("t5_drained_at_most_2", (accepts - a0) <= 2, 1);
    check("t5_fifo_kept", fifo_q.size(), 4);
    check("t5_busy_low", busy, 0);
    enable = 1;
    wait_idle(1, 40, "t5_finish");

    // Reset mid-burst with both buffer entries occupied.
    base = accepts;
    p0 = pops;
    for (int i = 0; i < 6; i++) push_word(BW'(32'h300 + i));
    wait_accepts(base + 1, 40, "t6_wait");
    out_ready = 0;
    repeat (4) step();
    check("t6_busy_before_reset", busy, 1);
    check("t6_pops_before_reset", pops - p0, 3);
    reset = 1;
    step();
    check("t6_rst_out_valid", bus.outValid, 0);
    check("t6_rst_beat_count", beat_count, 0);
    check("t6_rst_busy", busy, 0);
    reset = 0;
    out_ready = 1;
    a0 = accepts;
    for (int i = 0; i < 3; i++) push_word(BW'(32'h400 + i));
    wait_accepts(a0 + 6, 60, "t6_drain");
    wait_idle(1, 40, "t6_idle");

    // Randomised traffic, ready, enable and mid-burst length changes.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && (fifo_q.size() + push_req.size()) < FIFO_DEPTH)
        push_word(BW'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) burst_length = BL'($urandom_range(0, 6));
      step();
    end
    enable = 1;
    out_ready = 1;
    wait_idle(1, 200, "t7_drain");

    check("end_scoreboard_empty", exp_q.size(), 0);
    check("end_pop_accept_balance", pops - accepts, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
